// File: rtl/control_unit_if.sv
// Handshake and control bundle between the instruction sequencer and the
// datapath it steers.
interface control_unit_if;
    logic        run;
    logic [15:0] din;
    logic        g_nonzero;
    logic        ir_load;
    logic [7:0]  reg_in;
    logic [3:0]  bus_sel;
    logic        a_in;
    logic [2:0]  op_select;
    logic        g_in;
    logic        out_load;
    logic        done;

    // The sequencer side: it consumes run/din/g_nonzero and produces the strobes.
    modport slave (
        input  run, din, g_nonzero,
        output ir_load, reg_in, bus_sel, a_in, op_select, g_in, out_load, done
    );

    // The datapath / stimulus side.
    modport master (
        output run, din, g_nonzero,
        input  ir_load, reg_in, bus_sel, a_in, op_select, g_in, out_load, done
    );
endinterface

// File: rtl/control_unit.sv
// Multicycle instruction sequencer: captures a 9-bit instruction and walks
// T0..T3, decoding datapath strobes combinationally from state and IR.
module control_unit (
    input  logic           clock,
    input  logic           reset,
    control_unit_if.slave  cu
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;

    localparam logic [3:0] BUS_DIN  = 4'd8;
    localparam logic [3:0] BUS_G    = 4'd9;
    localparam logic [3:0] BUS_NONE = 4'd15;

    localparam logic [2:0] ULA_ADD  = 3'b000;
    localparam logic [2:0] ULA_SUB  = 3'b001;
    localparam logic [2:0] ULA_NAND = 3'b010;
    localparam logic [2:0] ULA_PASS = 3'b100;

    state_t     state;
    state_t     next_state;
    logic [8:0] ir;
    logic [2:0] opcode;
    logic [2:0] x_field;
    logic [2:0] y_field;
    logic [7:0] x_onehot;

    assign opcode   = ir[8:6];
    assign x_field  = ir[5:3];
    assign y_field  = ir[2:0];
    assign x_onehot = 8'b0000_0001 << x_field;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
            ir    <= 9'd0;
        end else begin
            state <= next_state;
            if (state == T0 && cu.run) begin
                ir <= cu.din[8:0];
            end
        end
    end

    always_comb begin
        next_state   = state;
        cu.ir_load   = 1'b0;
        cu.reg_in    = 8'd0;
        cu.bus_sel   = BUS_NONE;
        cu.a_in      = 1'b0;
        cu.op_select = ULA_ADD;
        cu.g_in      = 1'b0;
        cu.out_load  = 1'b0;
        cu.done      = 1'b0;

        unique case (state)
            T0: begin
                cu.ir_load = cu.run;
                if (cu.run) begin
                    next_state = T1;
                end
            end
            T1: begin
                unique case (opcode)
                    OP_MV: begin
                        cu.bus_sel = {1'b0, y_field};
                        cu.reg_in  = x_onehot;
                        cu.done    = 1'b1;
                        next_state = T0;
                    end
                    OP_MVI: begin
                        cu.bus_sel = BUS_DIN;
                        cu.reg_in  = x_onehot;
                        cu.done    = 1'b1;
                        next_state = T0;
                    end
                    OP_MVNZ: begin
                        cu.bus_sel = {1'b0, y_field};
                        cu.reg_in  = cu.g_nonzero ? x_onehot : 8'd0;
                        cu.done    = 1'b1;
                        next_state = T0;
                    end
                    OP_ADD, OP_SUB, OP_NAND, OP_OUT: begin
                        cu.bus_sel = {1'b0, x_field};
                        cu.a_in    = 1'b1;
                        next_state = T2;
                    end
                    default: begin
                        cu.done    = 1'b1;
                        next_state = T0;
                    end
                endcase
            end
            T2: begin
                next_state = T3;
                unique case (opcode)
                    OP_ADD: begin
                        cu.bus_sel   = {1'b0, y_field};
                        cu.op_select = ULA_ADD;
                        cu.g_in      = 1'b1;
                    end
                    OP_SUB: begin
                        cu.bus_sel   = {1'b0, y_field};
                        cu.op_select = ULA_SUB;
                        cu.g_in      = 1'b1;
                    end
                    OP_NAND: begin
                        cu.bus_sel   = {1'b0, y_field};
                        cu.op_select = ULA_NAND;
                        cu.g_in      = 1'b1;
                    end
                    OP_OUT: begin
                        cu.op_select = ULA_PASS;
                        cu.g_in      = 1'b1;
                    end
                    default: begin
                        next_state = T0;
                    end
                endcase
            end
            T3: begin
                next_state = T0;
                cu.bus_sel = BUS_G;
                cu.done    = 1'b1;
                if (opcode == OP_OUT) begin
                    cu.out_load = 1'b1;
                end else begin
                    cu.reg_in = x_onehot;
                end
            end
            default: begin
                next_state = T0;
            end
        endcase

        // Reset overrides everything so no write strobe escapes an aborted instruction.
        if (reset) begin
            cu.ir_load   = 1'b0;
            cu.reg_in    = 8'd0;
            cu.bus_sel   = BUS_NONE;
            cu.a_in      = 1'b0;
            cu.op_select = ULA_ADD;
            cu.g_in      = 1'b0;
            cu.out_load  = 1'b0;
            cu.done      = 1'b0;
        end
    end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle instruction sequencer that sits directly upstream of the ULA. It captures 9-bit instructions from the data bus and steps through timesteps T0–T3. In each timestep it drives the register-file write enables, the shared-bus source select, the ULA operand register A, the ULA `OpSelect` code and the result register G. The datapath (registers, bus mux, ULA, G, output register) lives outside this block; this block owns only the instruction register and the FSM.

## Interface
Parameters: none (instruction format and encodings fixed below).

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `run`  in  1  start request; sampled only in T0
- `din`  in  16  data bus input; instruction in `din[8:0]` when captured, immediate for `mvi`
- `g_nonzero`  in  1  from datapath, 1 when G != 0
- `ir_load`  out  1  IR capture strobe (informational copy to datapath)
- `reg_in`  out  8  one-hot write enable for R0..R7
- `bus_sel`  out  4  bus source: 0–7 = R0..R7, 8 = DIN, 9 = G, 15 = none
- `a_in`  out  1  load ULA operand register A from bus
- `op_select`  out  3  ULA op: 000 add (A+bus), 001 sub (A−bus), 010 nand, 100 pass A
- `g_in`  out  1  load G from ULA result
- `out_load`  out  1  load external output register from bus
- `done`  out  1  one-cycle pulse in final timestep of every instruction

## Operation
- Instruction fields, held in internal 9-bit IR:
  - opcode = IR[8:6], X = IR[5:3], Y = IR[2:0]
  - opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 nand, 101 mvnz, 110 out, 111 reserved (no-op)
- States T0, T1, T2, T3 (2-bit encoding).
- Defaults in every state unless listed: all strobes 0, `reg_in`=0, `bus_sel`=15, `op_select`=000.
- T0:
  - `ir_load`=`run`. If `run`=1, IR <= `din[8:0]` and go to T1; else stay in T0.
- T1:
  - mv: `bus_sel`=Y, `reg_in[X]`=1, `done`=1 -> T0.
  - mvi: `bus_sel`=8, `reg_in[X]`=1, `done`=1 -> T0.
  - mvnz: `bus_sel`=Y, `reg_in[X]`=`g_nonzero`, `done`=1 -> T0.
  - add/sub/nand/out: `bus_sel`=X, `a_in`=1 -> T2.
  - reserved: `done`=1, no writes -> T0.
- T2:
  - add/sub/nand: `bus_sel`=Y, `op_select`=000/001/010 respectively, `g_in`=1 -> T3.
  - out: `op_select`=100, `g_in`=1 -> T3.
- T3:
  - add/sub/nand: `bus_sel`=9, `reg_in[X]`=1, `done`=1 -> T0.
  - out: `bus_sel`=9, `out_load`=1, `done`=1 -> T0.
- X = Y is legal. For example, `add R3,R3` doubles R3; no special casing.
- Outputs are decoded combinationally from state and IR. `ir_load` also depends on `run`.

## Timing
- Reset: on a rising edge with `reset`=1, state <= T0 and IR <= 0. While `reset`=1, all outputs are forced to their defaults (all 0, `bus_sel`=15), including `ir_load`, irrespective of `run`.
- Reset mid-instruction (any of T1–T3) aborts the instruction with no write enable issued in the reset cycle. The next non-reset cycle is T0.
- Latency, counting from the T0 edge that captures the instruction to the `done` cycle inclusive:
  - mv, mvi, mvnz, reserved: 2 cycles
  - add, sub, nand, out: 4 cycles
- Back-to-back: after `done`, the FSM is in T0 on the next cycle. If `run` is held high, the next instruction is captured in that cycle, with no bubble beyond T0.
- `run` and `din` are ignored in T1–T3, except that `din` is the bus source in mvi T1.
- `g_nonzero` is sampled combinationally in mvnz T1 only.
- `done` is high for exactly one cycle per instruction and never high in T0.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles with `run`=1 -> all outputs 0, `bus_sel`=15, no `ir_load`. Release with `run`=0 -> stays in T0 with outputs idle.
- mvi R2 (din=9'b001_010_000): T1 with `din`=16'h0007 -> `bus_sel`=8, `reg_in`=8'b0000_0100, `done`=1; back in T0 next cycle.
- add R1,R5 (9'b010_001_101):
  - T1: `bus_sel`=1, `a_in`=1
  - T2: `bus_sel`=5, `op_select`=000, `g_in`=1
  - T3: `bus_sel`=9, `reg_in`=8'b0000_0010, `done`=1
  - repeat with sub (`op_select`=001) and nand (`op_select`=010).
- out R7 (9'b110_111_000): T1 `bus_sel`=7, `a_in`=1; T2 `op_select`=100, `g_in`=1; T3 `bus_sel`=9, `out_load`=1, `done`=1, `reg_in`=0.
- mvnz R0,R4 twice: with `g_nonzero`=0 -> `reg_in`=0, `done`=1; with `g_nonzero`=1 -> `reg_in`=8'b0000_0001, `bus_sel`=4.
- Reset in T2 of add -> no `g_in` or `reg_in` in the reset cycle, next cycle T0. With `run` held high, a following mv R6,R1 completes `done` 2 cycles after capture.
